// File: rtl/absdiff_pkg.sv
// Shared constants and state encoding for the absolute-difference scheduler.
package absdiff_pkg;

  localparam int unsigned DW_DEFAULT     = 10;
  localparam int unsigned RW             = 8;
  localparam int unsigned MOTO_ZERO_CASE = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/absdiff_sched_if.sv
// Request/response channels between the two search-front engines and the scheduler.
interface absdiff_sched_if #(
  parameter int unsigned DW = 10
);

  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_moto;
  logic [DW-1:0] req0_hikareru;
  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_moto;
  logic [DW-1:0] req1_hikareru;

  logic          rsp0_valid;
  logic          rsp0_ready;
  logic [DW-1:0] rsp0_sa;
  logic          rsp1_valid;
  logic          rsp1_ready;
  logic [DW-1:0] rsp1_sa;

  modport master (
    output req0_valid, req0_moto, req0_hikareru,
    output req1_valid, req1_moto, req1_hikareru,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_sa, rsp1_valid, rsp1_sa
  );

  modport slave (
    input  req0_valid, req0_moto, req0_hikareru,
    input  req1_valid, req1_moto, req1_hikareru,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_sa, rsp1_valid, rsp1_sa
  );

endinterface

// File: rtl/absdiff_sched_sub_plot.sv
// Shared absolute-difference unit: 8-bit wrapped |moto - hikareru|, zero when moto == 1.
module sub_plot
  import absdiff_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          in_do,
  input  logic [DW-1:0] moto,
  input  logic [DW-1:0] hikareru,
  output logic [DW-1:0] sa
);

  logic [RW-1:0] d;
  logic [RW-1:0] mag;
  logic          unused_hi;

  // Upper operand bits only matter for the moto == 1 test.
  assign unused_hi = ^hikareru[DW-1:RW];

  always_comb begin
    d   = moto[RW-1:0] - hikareru[RW-1:0];
    mag = d[RW-1] ? ((~d) + RW'(1)) : d;
    if (!in_do || (moto == DW'(MOTO_ZERO_CASE))) begin
      sa = '0;
    end else begin
      sa = {{(DW-RW){1'b0}}, mag};
    end
  end

endmodule

// File: rtl/absdiff_sched.sv
// Round-robin scheduler sharing one sub_plot unit between the forward and backward fronts.
module absdiff_sched
  import absdiff_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned CW = 16
) (
  input  logic          m_clock,
  input  logic          p_reset,
  absdiff_sched_if.slave bus,
  output logic          busy,
  output logic [CW-1:0] op_count
);

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          gnt_q, gnt_d;
  logic [DW-1:0] op_a_q, op_a_d;
  logic [DW-1:0] op_b_q, op_b_d;
  logic [DW-1:0] res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          in_do;
  logic [DW-1:0] sa;
  logic          sel;
  logic          done;
  logic          rdy0, rdy1, vld0, vld1;
  logic [DW-1:0] sa0, sa1;

  sub_plot #(
    .DW(DW)
  ) u_sub_plot (
    .in_do    (in_do),
    .moto     (op_a_q),
    .hikareru (op_b_q),
    .sa       (sa)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    in_do   = 1'b0;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    vld0    = 1'b0;
    vld1    = 1'b0;
    sa0     = '0;
    sa1     = '0;
    done    = 1'b0;
    // Contention goes to prio; a lone request wins regardless of prio.
    sel     = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;

    unique case (state_q)
      StIdle: begin
        if (bus.req0_valid || bus.req1_valid) begin
          rdy0    = ~sel;
          rdy1    = sel;
          gnt_d   = sel;
          prio_d  = ~sel;
          op_a_d  = sel ? bus.req1_moto : bus.req0_moto;
          op_b_d  = sel ? bus.req1_hikareru : bus.req0_hikareru;
          state_d = StExec;
        end
      end
      StExec: begin
        in_do   = 1'b1;
        res_d   = sa;
        state_d = StHold;
      end
      StHold: begin
        if (gnt_q) begin
          vld1 = 1'b1;
          sa1  = res_q;
          done = bus.rsp1_ready;
        end else begin
          vld0 = 1'b1;
          sa0  = res_q;
          done = bus.rsp0_ready;
        end
        if (done) begin
          if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + CW'(1);
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (!p_reset) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs read as zero for the whole time reset is held low.
  assign bus.req0_ready = p_reset & rdy0;
  assign bus.req1_ready = p_reset & rdy1;
  assign bus.rsp0_valid = p_reset & vld0;
  assign bus.rsp1_valid = p_reset & vld1;
  assign bus.rsp0_sa    = p_reset ? sa0 : '0;
  assign bus.rsp1_sa    = p_reset ? sa1 : '0;
  assign busy           = p_reset && (state_q != StIdle);
  assign op_count       = p_reset ? cnt_q : '0;

endmodule

// File: tb/tb_absdiff_sched.sv
// Randomized and directed bench for absdiff_sched against a transaction-level reference.
module tb_absdiff_sched;

  localparam int unsigned DW = 10;
  localparam int unsigned CW = 16;

  logic          m_clock;
  logic          p_reset;
  logic          busy;
  logic [CW-1:0] op_count;

  absdiff_sched_if #(.DW(DW)) bus ();

  absdiff_sched #(
    .DW(DW),
    .CW(CW)
  ) dut (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;

  // Reference state: at most one outstanding operation, accepted at m_acc.
  bit          m_out  = 1'b0;
  int          m_acc  = 0;
  bit          m_gnt  = 1'b0;
  bit          m_prio = 1'b0;
  logic [9:0]  m_res  = '0;
  int          m_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [9:0] ref_sa(input logic [9:0] m, input logic [9:0] h);
    int d;
    if (m == 10'd1) return 10'd0;
    d = (int'(m) - int'(h)) % 256;
    if (d < 0) d += 256;
    if (d >= 128) d = 256 - d;
    return 10'(d);
  endfunction

  task automatic step(input bit rst, input bit v0, input logic [9:0] m0, input logic [9:0] h0,
                      input bit v1, input logic [9:0] m1, input logic [9:0] h1,
                      input bit r0, input bit r1);
    bit         e_rdy0, e_rdy1, e_v0, e_v1, e_busy, g, hold;
    logic [9:0] e_sa0, e_sa1;
    int         e_cnt;
    @(negedge m_clock);
    p_reset           = rst;
    bus.req0_valid    = v0;
    bus.req0_moto     = m0;
    bus.req0_hikareru = h0;
    bus.req1_valid    = v1;
    bus.req1_moto     = m1;
    bus.req1_hikareru = h1;
    bus.rsp0_ready    = r0;
    bus.rsp1_ready    = r1;
    #1;
    e_rdy0 = 0; e_rdy1 = 0; e_v0 = 0; e_v1 = 0; e_busy = 0;
    e_sa0  = '0; e_sa1 = '0;
    e_cnt  = rst ? m_cnt : 0;
    g      = (v0 && v1) ? m_prio : v1;
    hold   = m_out && (cyc - m_acc >= 2);
    if (rst) begin
      if (!m_out) begin
        if (v0 || v1) begin
          e_rdy0 = !g;
          e_rdy1 = g;
        end
      end else begin
        e_busy = 1;
        if (hold) begin
          if (m_gnt) begin e_v1 = 1; e_sa1 = m_res; end
          else       begin e_v0 = 1; e_sa0 = m_res; end
        end
      end
    end
    check_eq("req0_ready", 32'(bus.req0_ready), 32'(e_rdy0));
    check_eq("req1_ready", 32'(bus.req1_ready), 32'(e_rdy1));
    check_eq("rsp0_valid", 32'(bus.rsp0_valid), 32'(e_v0));
    check_eq("rsp1_valid", 32'(bus.rsp1_valid), 32'(e_v1));
    check_eq("rsp0_sa",    32'(bus.rsp0_sa),    32'(e_sa0));
    check_eq("rsp1_sa",    32'(bus.rsp1_sa),    32'(e_sa1));
    check_eq("busy",       32'(busy),           32'(e_busy));
    check_eq("op_count",   32'(op_count),       32'(e_cnt));
    if (!rst) begin
      m_out  = 0;
      m_prio = 0;
      m_cnt  = 0;
    end else if (!m_out) begin
      if (v0 || v1) begin
        m_out  = 1;
        m_acc  = cyc;
        m_gnt  = g;
        m_prio = !g;
        m_res  = g ? ref_sa(m1, h1) : ref_sa(m0, h0);
      end
    end else if (hold && (m_gnt ? r1 : r0)) begin
      m_out = 0;
      if (m_cnt != 65535) m_cnt++;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit r0, input bit r1);
    for (int i = 0; i < n; i++) step(1, 0, '0, '0, 0, '0, '0, r0, r1);
  endtask

  initial begin
    logic [9:0] rm0, rh0, rm1, rh1;
    bit         rv0, rv1, rr0, rr1, rrst;

    // Reset held two cycles with every input active: outputs must still read zero.
    step(0, 1, 10'd3, 10'd4, 1, 10'd5, 10'd6, 1, 1);
    step(0, 1, 10'd3, 10'd4, 1, 10'd5, 10'd6, 1, 1);

    // Single op, then a changed operand after grant must be ignored.
    step(1, 1, 10'd50, 10'd20, 0, '0, '0, 1, 1);
    step(1, 1, 10'd99, 10'd0, 0, '0, '0, 1, 1);
    idle(3, 1, 1);

    // Negative difference, moto==1 case, 8-bit wrap.
    step(1, 0, '0, '0, 1, 10'd20, 10'd50, 1, 1);
    idle(3, 1, 1);
    step(1, 0, '0, '0, 1, 10'd1, 10'd5, 1, 1);
    idle(3, 1, 1);
    step(1, 1, 10'd200, 10'd10, 0, '0, '0, 1, 1);
    idle(3, 1, 1);

    // Continuous contention: grants alternate.
    for (int i = 0; i < 12; i++)
      step(1, 1, 10'(100 + i), 10'(7 * i), 1, 10'(3 * i), 10'(90 + i), 1, 1);
    idle(2, 1, 1);

    // Backpressure on channel 0 while requester 1 waits.
    step(1, 1, 10'd77, 10'd11, 0, '0, '0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, '0, '0, 1, 10'd9, 10'd40, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, '0, '0, 1, 10'd9, 10'd40, 1, 1);
    idle(2, 1, 1);

    // Reset while a response is being held; then requester 0 must win first.
    step(1, 1, 10'd60, 10'd5, 0, '0, '0, 0, 0);
    idle(3, 0, 0);
    step(0, 0, '0, '0, 0, '0, '0, 1, 1);
    idle(3, 1, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 10'd33, 10'd1, 1, 10'd1, 10'd33, 1, 1);
    idle(2, 1, 1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rrst = ($urandom_range(0, 299) != 0);
      rv0  = ($urandom_range(0, 9) < 6);
      rv1  = ($urandom_range(0, 9) < 6);
      rr0  = ($urandom_range(0, 1) == 1);
      rr1  = ($urandom_range(0, 1) == 1);
      rm0  = ($urandom_range(0, 7) == 0) ? 10'd1 : 10'($urandom_range(0, 1023));
      rh0  = 10'($urandom_range(0, 1023));
      rm1  = ($urandom_range(0, 7) == 0) ? 10'd1 : 10'($urandom_range(0, 1023));
      rh1  = 10'($urandom_range(0, 1023));
      step(rrst, rv0, rm0, rh0, rv1, rm1, rh1, rr0, rr1);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
